i2c_target_regs: RTL and testbench

- Parametrised I2C target with a CSR pointer interface. It is the next generation of the board-controller I2C slave.
- It responds to a maskable range of 7-bit device addresses and uses a register pointer of configurable width.
- It adds a read strobe for clear-on-read registers and reports which device address matched. It prefetches read data correctly, so sequential reads return consecutive registers.
- It sits between the board I2C pins and the CPLD register file.

---
 rtl/i2c_target_regs.sv | 172 +++++++++++++++++
 tb/tb_i2c_target_regs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target onto a CSR pointer bus: 1-clk csr_we/csr_re strobes, read byte prefetched 1 clk after the pointer settles.
// No clock stretching, so the master is never held off; define I2C_TIMEOUT_EN to add an SCL-low watchdog.
module i2c_target_regs #(
  parameter logic [6:0]  I2C_ADDRESS    = 7'h4a,
  parameter logic [6:0]  ADDR_MASK      = 7'h00,
  parameter int          IDX_WIDTH      = 5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire                  sda,
  input  logic                 scl,
  output logic [IDX_WIDTH-1:0] csr_a,
  input  logic [7:0]           csr_di,
  output logic [7:0]           csr_do,
  output logic                 csr_we,
  output logic                 csr_re,
  output logic [6:0]           dev_match,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, DEV_ADDR, IDX_PTR, WRITE, READ} state_t;

  state_t     state;
  logic [2:0] scl_sync;
  logic [2:0] sda_sync;
  logic [3:0] bit_cnt;
  logic [7:0] rx;
  logic [7:0] tx;
  logic       sda_oe;
  logic       load_pend;
  logic       inc_pend;

  logic start_c;
  logic stop_c;
  logic capture;
  logic update;
  logic ack_bit;
  logic addr_hit;
  logic timeout;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign start_c  = scl_sync[2] & scl_sync[1] & sda_sync[2] & ~sda_sync[1];
  assign stop_c   = scl_sync[2] & scl_sync[1] & ~sda_sync[2] & sda_sync[1];
  assign capture  = ~scl_sync[2] & scl_sync[1];
  assign update   = scl_sync[2] & ~scl_sync[1];
  assign ack_bit  = capture && (bit_cnt == 4'd8);
  assign addr_hit = ((rx[7:1] ^ I2C_ADDRESS) & ~ADDR_MASK) == 7'd0;

`ifdef I2C_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 16'd0;
    end else if (state == IDLE || scl_sync[1] || timeout) begin
      to_cnt <= 16'd0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout = (to_cnt == TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scl_sync  <= 3'b111;
      sda_sync  <= 3'b111;
      bit_cnt   <= 4'd0;
      rx        <= 8'd0;
      tx        <= 8'd0;
      sda_oe    <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
      csr_a     <= '0;
      csr_do    <= 8'd0;
      csr_we    <= 1'b0;
      csr_re    <= 1'b0;
      dev_match <= 7'd0;
      busy      <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[1:0], scl};
      sda_sync  <= {sda_sync[1:0], sda};
      csr_we    <= 1'b0;
      csr_re    <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;

      if (capture) rx <= {rx[6:0], sda_sync[1]};
      if (inc_pend) csr_a <= csr_a + IDX_WIDTH'(1);
      // csr_a already moved last clk, so csr_di now reflects the next register
      if (load_pend) begin
        tx     <= csr_di;
        csr_re <= 1'b1;
      end

      if (start_c) begin
        state   <= DEV_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_c) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else if (timeout) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        if (capture) bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;

        if (ack_bit) begin
          case (state)
            DEV_ADDR: begin
              if (!addr_hit) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                dev_match <= rx[7:1];
                busy      <= 1'b1;
                if (rx[0]) begin
                  state     <= READ;
                  load_pend <= 1'b1;
                end else begin
                  state <= IDX_PTR;
                end
              end
            end
            IDX_PTR: begin
              state <= WRITE;
              csr_a <= rx[IDX_WIDTH-1:0];
            end
            WRITE: begin
              csr_we   <= 1'b1;
              csr_do   <= rx;
              inc_pend <= 1'b1;
            end
            READ: begin
              if (sda_sync[1]) begin
                state <= IDLE;
              end else begin
                csr_a     <= csr_a + IDX_WIDTH'(1);
                load_pend <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (update) begin
          if (bit_cnt == 4'd8) begin
            sda_oe <= (state == DEV_ADDR && addr_hit) || state == IDX_PTR || state == WRITE;
          end else if (state == READ) begin
            sda_oe <= ~tx[7];
            tx     <= {tx[6:0], 1'b0};
          end else begin
            sda_oe <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register file behind the CSR port, array-based reference memory.
module tb_i2c_target_regs;
  localparam int IW = 5;
  localparam int Q  = 6;
  localparam int H  = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scl;
  logic          m_low;
  wire           sda;
  logic [IW-1:0] csr_a;
  logic [7:0]    csr_di;
  logic [7:0]    csr_do;
  logic          csr_we;
  logic          csr_re;
  logic [6:0]    dev_match;
  logic          busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_target_regs #(
    .I2C_ADDRESS(7'h4a), .ADDR_MASK(7'h01), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sda(sda), .scl(scl), .csr_a(csr_a), .csr_di(csr_di),
    .csr_do(csr_do), .csr_we(csr_we), .csr_re(csr_re), .dev_match(dev_match), .busy(busy)
  );

  logic [7:0]  regs [32];
  logic [7:0]  ref_mem [32];
  logic [7:0]  dbuf [4];
  logic [7:0]  rbuf [4];
  logic [12:0] wlog [$];
  logic        fill = 1'b0;
  logic        watch = 1'b0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          bad_drive = 0;
  int          n_checks = 0;
  int          n_err = 0;

  assign csr_di = regs[csr_a];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'(i + 8'h40);
    end else if (csr_we) begin
      regs[csr_a] <= csr_do;
      we_cnt      <= we_cnt + 1;
      wlog.push_back({csr_a, csr_do});
    end
    if (csr_re) re_cnt <= re_cnt + 1;
    if (watch && !m_low && sda === 1'b0) bad_drive <= bad_drive + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; cyc(Q); scl = 1'b1; cyc(H); m_low = 1'b1; cyc(H); scl = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; cyc(Q); scl = 1'b1; cyc(H); m_low = 1'b0; cyc(H);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_low = ~b; cyc(Q); scl = 1'b1; cyc(H); s = sda; scl = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // Bus write plus the reference memory update: pointer takes the low IW bits and wraps.
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n, output int nacks);
    logic ack;
    int   ptr;
    nacks = 0;
    i2c_start();
    send_byte({a, 1'b0}, ack); nacks += int'(ack);
    send_byte(p, ack);         nacks += int'(ack);
    for (int i = 0; i < n; i++) begin
      send_byte(dbuf[i], ack); nacks += int'(ack);
    end
    i2c_stop();
    ptr = int'(p) % 32;
    for (int i = 0; i < n; i++) begin
      ref_mem[ptr] = dbuf[i];
      ptr = (ptr + 1) % 32;
    end
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] p, input int n, output int nacks);
    logic ack;
    nacks = 0;
    i2c_start();
    send_byte({a, 1'b0}, ack); nacks += int'(ack);
    send_byte(p, ack);         nacks += int'(ack);
    i2c_start();
    send_byte({a, 1'b1}, ack); nacks += int'(ack);
    for (int i = 0; i < n; i++) recv_byte(i == n - 1, rbuf[i]);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] p;
    logic [6:0] a;
    logic [7:0] d;
    int         nk, we0, re0, wl0, n, mism;

    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; fill = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i + 8'h40);
    cyc(3);
    fill = 1'b0;
    chk("rst_sda", sda, 1'b1);
    chk("rst_csr_a", csr_a, 0);
    chk("rst_csr_do", csr_do, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_csr_re", csr_re, 0);
    chk("rst_dev_match", dev_match, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc(5);

    // Basic write with pointer auto-increment
    wl0 = wlog.size();
    i2c_start();
    send_byte(8'h94, ack); chk("wr_addr_ack", ack, 0);
    send_byte(8'h03, ack); chk("wr_ptr_ack", ack, 0);
    send_byte(8'hA5, ack); chk("wr_d0_ack", ack, 0);
    send_byte(8'h5A, ack); chk("wr_d1_ack", ack, 0);
    chk("wr_busy", busy, 1);
    chk("wr_dev_match", dev_match, 7'h4a);
    i2c_stop();
    chk("wr_busy_stop", busy, 0);
    chk("wr_count", wlog.size() - wl0, 2);
    chk("wr_log0", wlog[wl0], {5'd3, 8'hA5});
    chk("wr_log1", wlog[wl0 + 1], {5'd4, 8'h5A});
    chk("wr_csr_a", csr_a, 5);
    ref_mem[3] = 8'hA5; ref_mem[4] = 8'h5A;

    // Combined read across the pointer wrap
    re0 = re_cnt;
    do_read(7'h4a, 8'h1F, 2, nk);
    chk("crd_acks", nk, 0);
    chk("crd_byte0", rbuf[0], 8'h5F);
    chk("crd_byte1", rbuf[1], 8'h40);
    chk("crd_model1", rbuf[1], ref_mem[0]);
    chk("crd_re_cnt", re_cnt - re0, 2);
    chk("crd_csr_a", csr_a, 0);
    chk("crd_busy", busy, 0);

    // Masked address: 0x4b answers, 0x4c is ignored
    dbuf[0] = 8'hC3;
    do_write(7'h4b, 8'h10, 1, nk);
    chk("mask_4b_acks", nk, 0);
    chk("mask_4b_dev_match", dev_match, 7'h4b);
    we0 = we_cnt;
    i2c_start();
    watch = 1'b1;
    send_byte(8'h98, ack); chk("mask_4c_nack", ack, 1);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack); chk("mask_4c_data_nack", ack, 1);
    watch = 1'b0;
    chk("mask_4c_busy", busy, 0);
    i2c_stop();
    chk("mask_4c_no_we", we_cnt - we0, 0);
    chk("mask_4c_no_drive", bad_drive, 0);

    // Repeated START after 4 data bits aborts that byte
    we0 = we_cnt; wl0 = wlog.size();
    i2c_start();
    send_byte(8'h94, ack);
    send_byte(8'h08, ack);
    clk_bit(1'b1, ack); clk_bit(1'b0, ack); clk_bit(1'b1, ack); clk_bit(1'b0, ack);
    i2c_start();
    send_byte(8'h94, ack); chk("msr_addr_ack", ack, 0);
    send_byte(8'h09, ack);
    send_byte(8'h3C, ack);
    i2c_stop();
    chk("msr_we_cnt", we_cnt - we0, 1);
    chk("msr_log", wlog[wl0], {5'd9, 8'h3C});
    ref_mem[9] = 8'h3C;

    // Randomised write/read traffic against the reference memory
    for (int it = 0; it < 4; it++) begin
      a = ($urandom_range(0, 1) == 1) ? 7'h4b : 7'h4a;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
      do_write(a, p, n, nk);
      chk("rnd_wr_acks", nk, 0);
      chk("rnd_dev_match", dev_match, a);
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      re0 = re_cnt;
      do_read(7'h4a, p, n, nk);
      chk("rnd_rd_acks", nk, 0);
      for (int i = 0; i < n; i++) chk("rnd_rd_byte", rbuf[i], ref_mem[(int'(p) + i) % 32]);
      chk("rnd_re_cnt", re_cnt - re0, n);
    end

    // Async reset while the target drives a 0 data bit
    dbuf[0] = 8'h11;
    do_write(7'h4a, 8'h07, 1, nk);
    i2c_start();
    send_byte(8'h94, ack);
    send_byte(8'h07, ack);
    i2c_start();
    send_byte(8'h95, ack); chk("ar_addr_ack", ack, 0);
    m_low = 1'b0; cyc(Q); scl = 1'b1; cyc(H / 2);
    chk("ar_driving", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("ar_sda", sda, 1'b1);
    chk("ar_csr_a", csr_a, 0);
    chk("ar_busy", busy, 0);
    chk("ar_dev_match", dev_match, 0);
    chk("ar_strobes", {csr_we, csr_re}, 2'b00);
    chk("ar_csr_do", csr_do, 0);
    cyc(4); rst_n = 1'b1; cyc(4);
    scl = 1'b0; cyc(H);
    i2c_stop();
    i2c_start();
    send_byte(8'h95, ack); chk("ar_recover_ack", ack, 0);
    recv_byte(1'b1, d);
    i2c_stop();
    chk("ar_recover_byte", d, ref_mem[0]);

    // SCL held low with the ACK driven, mid-WRITE
    we0 = we_cnt;
    i2c_start();
    send_byte(8'h94, ack);
    send_byte(8'h02, ack);
    d = 8'h77;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], ack);
    m_low = 1'b0;
    cyc(200);
`ifdef I2C_TIMEOUT_EN
    chk("to_busy", busy, 0);
    chk("to_sda", sda, 1'b1);
`else
    chk("hold_busy", busy, 1);
    chk("hold_sda", sda, 1'b0);
`endif
    scl = 1'b1; cyc(H); ack = sda; scl = 1'b0; cyc(Q);
    cyc(4);
`ifdef I2C_TIMEOUT_EN
    chk("to_ack", ack, 1);
    chk("to_we_cnt", we_cnt - we0, 0);
`else
    chk("hold_ack", ack, 0);
    chk("hold_we_cnt", we_cnt - we0, 1);
    ref_mem[2] = 8'h77;
`endif
    i2c_stop();
    chk("final_busy", busy, 0);

    mism = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== ref_mem[i]) mism++;
    chk("regfile_vs_model", mism, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
